// File: rtl/game_flow_ctrl_if.sv
// Game-flow controller bus: button/crash/score/vsync inputs and status outputs.
// The master side drives inputs; the slave side is the controller.
interface game_flow_ctrl_if #(
  parameter int LIVES_W = 3,
  parameter int LEVEL_W = 2,
  parameter int SCORE_W = 16,
  parameter int ADD_W   = 4
);
  logic               v_sync_i;
  logic               press_vali_i;
  logic               crash_me_enemy_i;
  logic [ADD_W-1:0]   add_score_i;
  logic [1:0]         game_status_o;
  logic [LIVES_W-1:0] lives_o;
  logic [LEVEL_W-1:0] level_o;
  logic [SCORE_W-1:0] score_o;
  logic               invul_o;

  modport master (
    output v_sync_i, press_vali_i,
    output crash_me_enemy_i, add_score_i,
    input  game_status_o, lives_o,
    input  level_o, score_o, invul_o
  );

  modport slave (
    input  v_sync_i, press_vali_i,
    input  crash_me_enemy_i, add_score_i,
    output game_status_o, lives_o,
    output level_o, score_o, invul_o
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game status FSM, lives/invulnerability, saturating score and level progression.
// Optional EXTRA_LIFE_EN: each level-up grants a life up to LIVES_MAX.
module game_flow_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int LIVES_MAX    = 7,
  parameter int LIVES_W      = 3,
  parameter int LEVEL_NUM    = 4,
  parameter int LEVEL_W      = 2,
  parameter int SCORE_W      = 16,
  parameter int ADD_W        = 4,
  parameter int LEVEL_STEP   = 100,
  parameter int INVUL_FRAMES = 120,
  parameter int FRAME_W      = 8
) (
  input logic clk_vga,
  input logic rst,
  game_flow_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam int LIVES_START =
    (LIVES_INIT > LIVES_MAX) ? LIVES_MAX : LIVES_INIT;
  localparam logic [LIVES_W-1:0] L_INIT = LIVES_W'(LIVES_START);
  localparam logic [LIVES_W-1:0] L_ONE  = LIVES_W'(1);
  localparam logic [LEVEL_W-1:0] LV_TOP = LEVEL_W'(LEVEL_NUM - 1);
  localparam logic [SCORE_W-1:0] S_MAX  = '1;
  localparam logic [SCORE_W-1:0] S_STEP = SCORE_W'(LEVEL_STEP);
  localparam logic [FRAME_W-1:0] F_LOAD = FRAME_W'(INVUL_FRAMES);

  state_t             state_q;
  state_t             state_nx;
  logic               vs_q;
  logic               tick;
  logic [LIVES_W-1:0] lives_q;
  logic [LIVES_W-1:0] lives_nx;
  logic [LEVEL_W-1:0] level_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_nx;
  logic [SCORE_W-1:0] thr_q;
  logic [SCORE_W-1:0] thr_nx;
  logic [FRAME_W-1:0] inv_q;
  logic               run_en;
  logic               start_ld;
  logic               crash_hit;
  logic               fatal;
  logic               lvl_up;
  logic [SCORE_W:0]   s_sum;
  logic [SCORE_W:0]   t_sum;

  assign tick = vs_q & ~bus.v_sync_i;

  always_ff @(posedge clk_vga) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.press_vali_i) state_nx = ST_RUN;
      ST_RUN: begin
        if (fatal)                  state_nx = ST_OVER;
        else if (bus.press_vali_i)  state_nx = ST_PAUSE;
      end
      ST_PAUSE: if (bus.press_vali_i) state_nx = ST_RUN;
      ST_OVER:  if (bus.press_vali_i) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    run_en    = (state_q == ST_RUN);
    start_ld  = (state_q == ST_IDLE) & bus.press_vali_i;
    crash_hit = run_en & bus.crash_me_enemy_i & (inv_q == '0);
    fatal     = crash_hit & (lives_q == L_ONE);
    lvl_up    = run_en & (score_q >= thr_q) & (level_q < LV_TOP);
  end

  always_comb begin
    s_sum    = {1'b0, score_q} + (SCORE_W+1)'(bus.add_score_i);
    score_nx = s_sum[SCORE_W] ? S_MAX : s_sum[SCORE_W-1:0];
    t_sum    = {1'b0, thr_q} + {1'b0, S_STEP};
    thr_nx   = t_sum[SCORE_W] ? S_MAX : t_sum[SCORE_W-1:0];
  end

  // A life gained on level-up cancels a coincident non-fatal hit.
  always_comb begin
    lives_nx = lives_q;
    if (fatal) begin
      lives_nx = '0;
    end else begin
      if (crash_hit) lives_nx = lives_q - L_ONE;
`ifdef EXTRA_LIFE_EN
      if (lvl_up && (lives_nx < LIVES_W'(LIVES_MAX)))
        lives_nx = lives_nx + L_ONE;
`endif
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vs_q    <= 1'b1;
      lives_q <= L_INIT;
      level_q <= '0;
      score_q <= '0;
      thr_q   <= S_STEP;
      inv_q   <= '0;
    end else begin
      vs_q <= bus.v_sync_i;
      if (start_ld) begin
        lives_q <= L_INIT;
        level_q <= '0;
        score_q <= '0;
        thr_q   <= S_STEP;
        inv_q   <= '0;
      end else if (run_en) begin
        lives_q <= lives_nx;
        score_q <= score_nx;
        if (lvl_up) begin
          level_q <= level_q + 1'b1;
          thr_q   <= thr_nx;
        end
        if (crash_hit && !fatal)
          inv_q <= F_LOAD;
        else if (tick && (inv_q != '0))
          inv_q <= inv_q - 1'b1;
      end
    end
  end

  assign bus.game_status_o = state_q;
  assign bus.lives_o       = lives_q;
  assign bus.level_o       = level_q;
  assign bus.score_o       = score_q;
  assign bus.invul_o       = (inv_q != '0);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: status flow, lives/invul, score, levels.
// Second instance with SCORE_W=8 covers score saturation.
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  game_flow_ctrl_if #(.SCORE_W(16)) g ();
  game_flow_ctrl_if #(.SCORE_W(8))  g8 ();

  game_flow_ctrl #(.SCORE_W(16)) dut (
    .clk_vga (clk),
    .rst     (rst),
    .bus     (g.slave)
  );

  game_flow_ctrl #(.SCORE_W(8)) dut8 (
    .clk_vga (clk),
    .rst     (rst),
    .bus     (g8.slave)
  );

`ifdef EXTRA_LIFE_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  task automatic check(input string tag,
                       input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press();
    g.press_vali_i = 1'b1;
    cyc();
    g.press_vali_i = 1'b0;
  endtask

  task automatic crash();
    g.crash_me_enemy_i = 1'b1;
    cyc();
    g.crash_me_enemy_i = 1'b0;
  endtask

  task automatic add(input int pts);
    g.add_score_i = 4'(pts);
    cyc();
    g.add_score_i = '0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      g.v_sync_i = 1'b0;
      cyc();
      g.v_sync_i = 1'b1;
      cyc();
    end
  endtask

  initial begin
    g.v_sync_i = 1'b1;
    g.press_vali_i = 1'b0;
    g.crash_me_enemy_i = 1'b0;
    g.add_score_i = '0;
    g8.v_sync_i = 1'b1;
    g8.press_vali_i = 1'b0;
    g8.crash_me_enemy_i = 1'b0;
    g8.add_score_i = '0;
    cyc(3);
    rst = 1'b0;

    check("rst_status", g.game_status_o, 0);
    check("rst_lives", g.lives_o, 3);
    check("rst_score", g.score_o, 0);
    check("rst_level", g.level_o, 0);
    check("rst_invul", g.invul_o, 0);

    press();
    check("start_status", g.game_status_o, 1);
    check("start_lives", g.lives_o, 3);
    press();
    check("pause_status", g.game_status_o, 2);
    press();
    check("resume_status", g.game_status_o, 1);

    crash();
    check("hit1_lives", g.lives_o, 2);
    check("hit1_invul", g.invul_o, 1);
    frames(10);
    crash();
    check("invul_ignore", g.lives_o, 2);
    frames(109);
    check("invul_119", g.invul_o, 1);
    frames(1);
    check("invul_120", g.invul_o, 0);
    crash();
    check("hit2_lives", g.lives_o, 1);
    frames(120);
    check("invul_clr2", g.invul_o, 0);

    g.crash_me_enemy_i = 1'b1;
    g.press_vali_i = 1'b1;
    cyc();
    g.crash_me_enemy_i = 1'b0;
    g.press_vali_i = 1'b0;
    check("fatal_status", g.game_status_o, 3);
    check("fatal_lives", g.lives_o, 0);
    press();
    check("over_idle", g.game_status_o, 0);

    add(5);
    check("idle_noscore", g.score_o, 0);
    press();
    check("restart_lives", g.lives_o, 3);
    for (int i = 0; i < 10; i++) add(10);
    check("score_100", g.score_o, 100);
    check("lvl_pre", g.level_o, 0);
    cyc();
    check("lvl_1", g.level_o, 1);
    check("xl_lives1", g.lives_o, 3 + XL);
    for (int i = 0; i < 11; i++) add(9);
    cyc(2);
    check("score_199", g.score_o, 199);
    check("lvl_hold", g.level_o, 1);
    add(1);
    cyc();
    check("lvl_2", g.level_o, 2);
    check("xl_lives2", g.lives_o, 3 + 2 * XL);

    crash();
    check("hit3_lives", g.lives_o, 2 + 2 * XL);
    frames(5);
    press();
    check("pause2", g.game_status_o, 2);
    crash();
    add(5);
    frames(200);
    check("pz_lives", g.lives_o, 2 + 2 * XL);
    check("pz_score", g.score_o, 200);
    check("pz_invul", g.invul_o, 1);
    press();
    frames(114);
    check("pz_inv114", g.invul_o, 1);
    frames(1);
    check("pz_inv115", g.invul_o, 0);

    g.crash_me_enemy_i = 1'b1;
    g.press_vali_i = 1'b1;
    cyc();
    g.crash_me_enemy_i = 1'b0;
    g.press_vali_i = 1'b0;
    check("nf_status", g.game_status_o, 2);
    check("nf_lives", g.lives_o, 1 + 2 * XL);

    g8.press_vali_i = 1'b1;
    cyc();
    g8.press_vali_i = 1'b0;
    g8.add_score_i = 4'd10;
    cyc(25);
    check("s8_250", g8.score_o, 250);
    g8.add_score_i = 4'd15;
    cyc();
    check("s8_sat", g8.score_o, 255);
    cyc();
    g8.add_score_i = '0;
    check("s8_hold", g8.score_o, 255);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_status", g.game_status_o, 0);
    check("mrst_score", g.score_o, 0);
    check("mrst_level", g.level_o, 0);
    check("mrst_lives", g.lives_o, 3);
    check("mrst_s8", g8.score_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
